// File: rtl/prng_pkg.sv
// Shared defaults and state encoding for the xorshift burst generator.
package prng_pkg;

  localparam int unsigned DefWidth  = 32;
  localparam int unsigned DefNumOut = 256;
  localparam int unsigned DefShA    = 13;
  localparam int unsigned DefShB    = 17;
  localparam int unsigned DefShC    = 5;

  // FSM encoding kept as plain constants for compatibility with older consumers.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GEN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/xorshift_step.sv
// One combinational xorshift step: v ^= v<<a; v ^= v>>b; v ^= v<<c.
module xorshift_step
  import prng_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned SH_A  = DefShA,
  parameter int unsigned SH_B  = DefShB,
  parameter int unsigned SH_C  = DefShC
) (
  input  logic [WIDTH-1:0] v_in,
  output logic [WIDTH-1:0] v_out
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;

  // Three xor-shift stages; shifts are logical and truncate to WIDTH.
  always_comb begin
    s1    = v_in ^ (v_in << SH_A);
    s2    = s1 ^ (s1 >> SH_B);
    v_out = s2 ^ (s2 << SH_C);
  end

endmodule

// File: rtl/prng_burst_gen.sv
// Consumes one synchronized seed per job and writes NUM_OUT xorshift words into a FIFO,
// stalling on fifo_full. busy covers the whole job so the upstream synchronizer holds off.
module prng_burst_gen
  import prng_pkg::*;
#(
  parameter int unsigned WIDTH   = DefWidth,
  parameter int unsigned NUM_OUT = DefNumOut,
  parameter int unsigned SH_A    = DefShA,
  parameter int unsigned SH_B    = DefShB,
  parameter int unsigned SH_C    = DefShC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             fifo_full,
  output logic             busy,
  output logic             out_valid,
  output logic [WIDTH-1:0] rand_num,
  output logic             done
);

  // Wide enough to hold NUM_OUT itself, so the count never wraps inside a job.
  localparam int unsigned     CntW    = $clog2(NUM_OUT + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(NUM_OUT - 1);

  logic [1:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] x_q, x_d, x_next;
  logic             busy_q, busy_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] rand_q, rand_d;
  logic             done_q, done_d;

  xorshift_step #(
    .WIDTH (WIDTH),
    .SH_A  (SH_A),
    .SH_B  (SH_B),
    .SH_C  (SH_C)
  ) u_step (
    .v_in  (x_q),
    .v_out (x_next)
  );

  // Next-state: seed capture in IDLE, one step per non-full cycle in GEN, one-cycle DONE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    x_d         = x_q;
    busy_d      = busy_q;
    out_valid_d = 1'b0;
    rand_d      = rand_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = seed_in;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = GEN;
        end
      end
      GEN: begin
        // A full FIFO freezes x, cnt and rand_num so no value is skipped or repeated.
        if (!fifo_full) begin
          rand_d      = x_next;
          x_d         = x_next;
          out_valid_d = 1'b1;
          cnt_d       = cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any job in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      x_q         <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      rand_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      rand_q      <= rand_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign rand_num  = rand_q;
  assign done      = done_q;

endmodule

// File: tb/tb_prng_burst_gen.sv
// Bench for prng_burst_gen: table of jobs plus hand-written reset sequence, with a
// queue-based scoreboard that checks every edge.
module tb_prng_burst_gen;

  localparam int unsigned W  = 32;
  localparam int unsigned NO = 256;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] seed_in;
  logic         fifo_full;
  logic         busy;
  logic         out_valid;
  logic [W-1:0] rand_num;
  logic         done;

  prng_burst_gen #(
    .WIDTH   (W),
    .NUM_OUT (NO),
    .SH_A    (13),
    .SH_B    (17),
    .SH_C    (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .seed_in   (seed_in),
    .fifo_full (fifo_full),
    .busy      (busy),
    .out_valid (out_valid),
    .rand_num  (rand_num),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] xs(input logic [W-1:0] v);
    logic [W-1:0] t;
    t = v;
    t = t ^ (t << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  // Scoreboard: expected words of the accepted job, in order.
  logic [W-1:0] exp_q[$];
  bit           m_busy     = 0;
  bit           m_done_due = 0;
  int           job_words  = 0;
  logic [W-1:0] job_first  = '0;
  logic [W-1:0] job_second = '0;
  logic         full_s, rst_s, inv_s;
  logic [W-1:0] seed_s;

  task automatic model_edge();
    bit           exp_ov;
    bit           busy_pre;
    logic [W-1:0] w;
    logic [W-1:0] v;
    if (rst_s) begin
      exp_q.delete();
      m_busy     = 0;
      m_done_due = 0;
      chk("rst_out_valid", W'(out_valid), '0);
      chk("rst_busy", W'(busy), '0);
      chk("rst_done", W'(done), '0);
      chk("rst_rand_num", rand_num, '0);
      return;
    end
    busy_pre = m_busy;
    exp_ov   = m_busy && (exp_q.size() > 0) && !full_s;
    chk("out_valid", W'(out_valid), W'(exp_ov));
    chk("done", W'(done), W'(m_done_due));
    if (m_done_due) begin
      m_busy     = 0;
      m_done_due = 0;
    end else if (exp_ov) begin
      w = exp_q.pop_front();
      chk("word", rand_num, w);
      if (job_words == 0) job_first = rand_num;
      if (job_words == 1) job_second = rand_num;
      job_words++;
      if (exp_q.size() == 0) m_done_due = 1;
    end
    if (inv_s && !busy_pre) begin
      v = seed_s;
      for (int i = 0; i < int'(NO); i++) begin
        v = xs(v);
        exp_q.push_back(v);
      end
      m_busy    = 1;
      job_words = 0;
    end
    chk("busy", W'(busy), W'(m_busy));
  endtask

  always @(posedge clk) begin
    full_s = fifo_full;
    rst_s  = rst;
    inv_s  = in_valid;
    seed_s = seed_in;
    #1;
    model_edge();
  end

  typedef struct {
    logic [W-1:0] seed;
    int           full_mode;   // 0 never, 1 edges 3..7, 2 toggle, 3 random
    int           pulse_mode;  // 0 none, 1 one pulse mid-burst, 2 held high, 3 random
    int           gap;
    logic [W-1:0] exp_first;
    logic [W-1:0] exp_second;
  } vec_t;

  vec_t vecs[12];

  task automatic run_job(input vec_t v);
    int cyc;
    bit seen;
    repeat (v.gap) @(negedge clk);
    seed_in  = v.seed;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cyc      = 0;
    seen     = 0;
    while (!seen && cyc < 4 * int'(NO) + 50) begin
      case (v.full_mode)
        0:       fifo_full = 1'b0;
        1:       fifo_full = (cyc >= 2 && cyc <= 6);
        2:       fifo_full = cyc[0];
        default: fifo_full = ($urandom_range(0, 3) == 0);
      endcase
      case (v.pulse_mode)
        0: in_valid = 1'b0;
        1: begin
          in_valid = (cyc == 50);
          seed_in  = 32'hDEAD_BEEF;
        end
        2: begin
          in_valid = 1'b1;
          seed_in  = $urandom;
        end
        default: begin
          in_valid = ($urandom_range(0, 19) == 0);
          seed_in  = $urandom;
        end
      endcase
      @(posedge clk);
      #1;
      seen = done;
      cyc++;
    end
    in_valid  = 1'b0;
    fifo_full = 1'b0;
    chk("job_done_seen", W'(seen), W'(1));
    @(negedge clk);
    chk("job_word_count", W'(job_words), W'(NO));
    chk("job_first", job_first, v.exp_first);
    chk("job_second", job_second, v.exp_second);
    chk("job_busy_after", W'(busy), '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    rst       = 1'b1;
    in_valid  = 1'b0;
    seed_in   = '0;
    fifo_full = 1'b0;

    vecs[0] = '{32'h1, 0, 0, 2, 32'h0004_2021, 32'h0408_0601};
    vecs[1] = '{32'h1, 1, 0, 3, 32'h0004_2021, 32'h0408_0601};
    vecs[2] = '{32'h1, 0, 1, 1, 32'h0004_2021, 32'h0408_0601};
    vecs[3] = '{32'h0, 0, 0, 2, 32'h0, 32'h0};
    vecs[4] = '{32'h1234_5678, 0, 0, 1, xs(32'h1234_5678), xs(xs(32'h1234_5678))};
    vecs[5] = '{32'hCAFE_F00D, 2, 0, 0, xs(32'hCAFE_F00D), xs(xs(32'hCAFE_F00D))};
    vecs[6] = '{32'h1, 3, 2, 2, 32'h0004_2021, 32'h0408_0601};
    for (int i = 7; i < 12; i++) begin
      vecs[i].seed       = $urandom;
      vecs[i].full_mode  = 3;
      vecs[i].pulse_mode = 3;
      vecs[i].gap        = $urandom_range(0, 3);
      vecs[i].exp_first  = xs(vecs[i].seed);
      vecs[i].exp_second = xs(xs(vecs[i].seed));
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", W'(busy), '0);
    chk("reset_out_valid", W'(out_valid), '0);
    chk("reset_done", W'(done), '0);
    chk("reset_rand_num", rand_num, '0);

    for (int i = 0; i < 12; i++) begin
      run_job(vecs[i]);
    end

    // Reset in the middle of a burst, then restart from seed 1.
    @(negedge clk);
    seed_in  = 32'h1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    guard    = 0;
    while (job_words < 100 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    chk("midrst_reached_100", W'(job_words), W'(100));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_out_valid", W'(out_valid), '0);
    chk("midrst_busy", W'(busy), '0);
    chk("midrst_done", W'(done), '0);
    repeat (3) @(negedge clk);
    chk("midrst_idle_busy", W'(busy), '0);
    run_job('{32'h1, 0, 0, 0, 32'h0004_2021, 32'h0408_0601});

    repeat (4) @(negedge clk);
    chk("final_queue_empty", W'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
